fetch_pc_ctrl: RTL
==================

FETCH_PC_CTRL -- requirements
Module: fetch_pc_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, address the PC takes on reset.
REQ-002 Parameter EXC_ENTRY, default 32'h0000_4180, exception/interrupt handler entry address.
REQ-003 Parameter IM_BASE, default 32'h0000_3000, byte address of instruction-memory word 0.
REQ-004 Parameter IM_AW, default 12, instruction-memory word-address width (depth 2^IM_AW words).
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 stall  input  1  hold the PC this cycle.
REQ-008 npc  input  32  next sequential or branch PC, from the next-PC logic.
REQ-009 exc_req  input  1  exception/interrupt redirect request.
REQ-010 eret  input  1  return-from-exception request.
REQ-011 epc  input  32  return address, used when eret wins.
REQ-012 pc  output  32  current fetch PC, registered.
REQ-013 im_addr  output  IM_AW  instruction-memory word index for pc.
REQ-014 adel  output  1  fetch address error for pc (misaligned or out of range).
REQ-015 redirected  output  1  registered pulse, high for the cycle after an exc_req or eret load.
REQ-016 adv_cnt  output  32  count of cycles in which pc was updated since reset.

Function
REQ-017 Next-pc priority SHALL be: reset > exc_req > eret > stall > npc.
REQ-018 If exc_req=1, pc SHALL load EXC_ENTRY regardless of stall, eret or npc.
REQ-019 If eret=1 and exc_req=0, pc SHALL load epc regardless of stall.
REQ-020 If stall=1 and neither exc_req nor eret is high, pc SHALL hold its value.
REQ-021 Otherwise, pc SHALL load npc on the rising edge.
REQ-022 Each load takes exactly one cycle; the new pc is visible on the cycle after the edge.
REQ-023 redirected SHALL be 1 in the cycle after a load caused by exc_req or eret, and 0 otherwise.
REQ-024 redirected SHALL NOT stay high for consecutive cycles unless a redirect occurs on each of those cycles.
REQ-025 adv_cnt SHALL increment by 1 on every edge where pc is loaded, whether from exc_req, eret or npc; it SHALL NOT increment on a hold.
REQ-026 adv_cnt SHALL wrap from 32'hFFFF_FFFF to 0 without any flag.
REQ-027 adel SHALL be combinational from pc. It SHALL be 1 if pc[1:0]!=0, if pc<IM_BASE, or if pc>=IM_BASE+(4<<IM_AW); else 0.
REQ-028 All range arithmetic SHALL use 33-bit unsigned compares so that IM_BASE+(4<<IM_AW) cannot overflow.
REQ-029 When adel=0, im_addr SHALL equal (pc-IM_BASE)[IM_AW+1:2].
REQ-030 When adel=1, im_addr SHALL be 0.
REQ-031 pc SHALL accept any 32-bit load value, including misaligned or out-of-range values; the error is reported only through adel, and pc is never truncated or corrected.
REQ-032 The block SHALL have no combinational path from any input to pc, redirected or adv_cnt.

Reset
REQ-033 While reset=1 at an edge, the block SHALL set pc=RESET_PC, redirected=0 and adv_cnt=0, overriding exc_req, eret and stall.
REQ-034 Reset asserted mid-operation, including in the cycle of a redirect, SHALL discard the pending load; redirected SHALL be 0 on the following cycle.
REQ-035 With default parameters, the reset outputs SHALL be im_addr=0 and adel=0.

Verification
REQ-036 Reset then three edges with npc=pc+4 and stall=0 -> pc=3000, 3004, 3008, 300C; im_addr=0, 1, 2, 3; adv_cnt=3.
REQ-037 At pc=3008, stall=1 for 2 cycles with npc=300C -> pc stays 3008 and adv_cnt is unchanged; after release, pc=300C.
REQ-038 stall=1, exc_req=1 and eret=1 together -> pc=4180 next cycle; redirected=1 for one cycle; adv_cnt+1.
REQ-039 eret=1 with epc=3010 and stall=1 -> pc=3010 and redirected=1; next cycle with no redirect -> redirected=0.
REQ-040 npc=3002 -> adel=1 and im_addr=0; npc=2FFC -> adel=1; npc=7000 with default IM_AW -> adel=1; npc=6FFC -> adel=0 and im_addr=FFF.
REQ-041 reset asserted in the same cycle as exc_req after 5 advances -> pc=3000, adv_cnt=0 and redirected=0.

Source files
------------

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC register with redirect priority, instruction-memory address
// decode and fetch address-error detection.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_BASE   = 32'h0000_3000,
  parameter int unsigned IM_AW     = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [31:0]      npc,
  input  logic             exc_req,
  input  logic             eret,
  input  logic [31:0]      epc,
  output logic [31:0]      pc,
  output logic [IM_AW-1:0] im_addr,
  output logic             adel,
  output logic             redirected,
  output logic [31:0]      adv_cnt
);

  // Range bounds held at 33 bits so the upper limit cannot wrap.
  localparam logic [32:0] IM_LO = {1'b0, IM_BASE};
  localparam logic [32:0] IM_HI = {1'b0, IM_BASE} + (33'd4 << IM_AW);

  logic [32:0] pc_ext;
  logic        misaligned;
  logic        out_of_range;

  assign pc_ext = {1'b0, pc};

  // Fetch address error and word index, purely from the current pc.
  always_comb begin
    misaligned   = (pc[1:0] != 2'b00);
    out_of_range = (pc_ext < IM_LO) || (pc_ext >= IM_HI);
    adel         = misaligned || out_of_range;
    im_addr      = '0;
    if (!adel) begin
      im_addr = IM_AW'((pc - IM_BASE) >> 2);
    end
  end

  // PC update: reset > exc_req > eret > stall > npc; count every load.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      redirected <= 1'b0;
      adv_cnt    <= '0;
    end else if (exc_req) begin
      pc         <= EXC_ENTRY;
      redirected <= 1'b1;
      adv_cnt    <= adv_cnt + 32'd1;
    end else if (eret) begin
      pc         <= epc;
      redirected <= 1'b1;
      adv_cnt    <= adv_cnt + 32'd1;
    end else if (stall) begin
      redirected <= 1'b0;
    end else begin
      pc         <= npc;
      redirected <= 1'b0;
      adv_cnt    <= adv_cnt + 32'd1;
    end
  end

endmodule
